prbs_mchk: RTL
==============

Name: prbs_mchk

Overview:
- Parametrised, synthesizable successor to the 8-bit PRBS7 self-syncing checker.
- Checks a WIDTH-bit parallel word stream against a runtime-selectable PRBS polynomial (PRBS7/9/15/23/31).
- Runs a seed/verify/lock state machine, counts bit errors and checked bits with saturation, and drops lock on sustained errors.
- Sits behind the comparator DUT's deserialised output in the PRBS phase of the comparator characterisation bench, and is also usable as on-chip BIST.

Parameters:
- WIDTH, 8, bits per input word; legal range 1..64.
- ERR_CNT_W, 32, width of the saturating error-bit counter.
- BIT_CNT_W, 48, width of the saturating checked-bit counter.
- LOCK_THRESH, 4, consecutive clean words in VERIFY required to declare lock; must be 1..255.
- UNLOCK_THRESH, 8, consecutive errored words in LOCKED that cause loss of lock; must be 1..255.

Ports:
- clk  in  1  Rising-edge clock.
- rst  in  1  Synchronous, active-high reset.
- en  in  1  Checker enable; when low, forces SEARCH and holds counters.
- mode  in  3  Polynomial select: 0=PRBS7 (x^7+x^6+1), 1=PRBS9 (x^9+x^5+1), 2=PRBS15 (x^15+x^14+1), 3=PRBS23 (x^23+x^18+1), 4=PRBS31 (x^31+x^28+1); 5..7 are treated as PRBS7.
- din  in  WIDTH  Received word; din[0] is the earliest bit in time.
- din_valid  in  1  Qualifies din; words are consumed only when high.
- clr_cnt  in  1  Synchronous clear of err_cnt and bit_cnt.
- state  out  2  0=SEARCH, 1=VERIFY, 2=LOCKED.
- locked  out  1  High iff state==LOCKED.
- err  out  1  One-cycle pulse: the last consumed word in LOCKED had at least one mismatch.
- err_bits  out  7  Popcount of mismatches in the last consumed word (0..WIDTH); 0 outside LOCKED.
- err_cnt  out  ERR_CNT_W  Saturating total of mismatched bits seen while LOCKED.
- bit_cnt  out  BIT_CNT_W  Saturating total of bits checked while LOCKED.

Behaviour:
- Reset: state=SEARCH, LFSR state=0, fill count=0, run counters=0; all outputs 0.
- Reset has priority over every other input.
- Order N = 7/9/15/23/31 according to mode.
- Internal state is a 31-bit history register; only the low N bits are used.
- Prediction recurrence: b[n] = b[n-N] xor b[n-T], where T=6/5/14/18/28.
- The WIDTH predicted bits per word are computed combinationally, unrolled in time order from din[0] to din[WIDTH-1].

SEARCH:
- Each valid word is shifted into the history register; fill count += WIDTH, saturating at 31.
- Once fill count >= N after a word, go to VERIFY on the next clock.
- The history register then holds the last N received bits.
- No comparison is made in SEARCH.

VERIFY:
- Each valid word is compared with the predicted word.
- Any mismatch: return to SEARCH; fill count is cleared, then this word's WIDTH bits are loaded as fresh history.
- Clean word: clean run += 1 and the history register advances with the predicted bits.
- When clean run reaches LOCK_THRESH, go to LOCKED.

LOCKED:
- History advances with predicted bits only, so received errors do not propagate.
- For each valid word, on the next cycle:
  - err_bits = popcount(din xor predicted);
  - err = (err_bits != 0);
  - err_cnt += err_bits, saturating at all-ones;
  - bit_cnt += WIDTH, saturating at all-ones.
- Consecutive errored-word counter: increments on an errored word and resets to 0 on a clean word.
- Reaching UNLOCK_THRESH: go to SEARCH with fill count=0; counters are held.

Common rules:
- Latency: err, err_bits and counter updates appear exactly 1 clk after the din_valid cycle.
- state and locked change on that same edge.
- din_valid low: no state change; err=0, err_bits=0.
- en low: state goes to SEARCH next cycle; fill count and run counters are cleared; counters are held; err=0.
- A mode change while not in SEARCH forces SEARCH next cycle; the word in that cycle is discarded.
- clr_cnt in the same cycle as an errored valid word: clear wins, err_cnt=0 and bit_cnt=0, but the err pulse is still emitted.
- Saturated counters stay at all-ones until clr_cnt or rst.

Test Plan:
- Basic lock: rst, mode=0, WIDTH=8, clean PRBS7 from seed 7'h7F, din_valid every cycle -> state=VERIFY after word 1; locked=1 exactly 1 clk after word 5 (1 search + 4 verify); err_cnt=0; bit_cnt=800 after 100 locked words.
- Error injection: locked PRBS15; flip din[3] in one word and din[0],din[7] in a later word -> err pulses twice with err_bits=1 then 2; err_cnt=3; no error multiplication; lock retained.
- Loss of lock: locked PRBS31; replace 8 consecutive words with 8'hFF -> locked drops 1 clk after the 8th word; state=SEARCH; relocks after clean data returns (4 search words + 4 verify words).
- VERIFY abort and mode switch: PRBS9, error in the 2nd VERIFY word -> back to SEARCH with no lock. Switching mode 0->3 while locked -> SEARCH next clk; counters unchanged.
- Saturation and clear: ERR_CNT_W=4; inject 20 single-bit errors -> err_cnt=15 and held; clr_cnt with a simultaneous errored word -> err_cnt=0 and err=1.
- Reset and enable mid-run: rst asserted while LOCKED -> all outputs 0 next clk. en low for 3 cycles -> SEARCH and counters held; valid gaps (din_valid toggling 1,0,1) -> lock timing counts valid words only.

Source files
------------

// File: rtl/prbs_mchk.sv
// prbs_mchk: parallel-word PRBS checker with runtime polynomial select.
// Self-synchronises from the received stream (SEARCH), confirms the seed
// over a run of clean words (VERIFY), then free-runs its own predictor
// (LOCKED) while counting mismatched and checked bits with saturation.
module prbs_mchk #(
    parameter int WIDTH         = 8,
    parameter int ERR_CNT_W     = 32,
    parameter int BIT_CNT_W     = 48,
    parameter int LOCK_THRESH   = 4,
    parameter int UNLOCK_THRESH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [2:0]           mode,
    input  logic [WIDTH-1:0]     din,
    input  logic                 din_valid,
    input  logic                 clr_cnt,
    output logic [1:0]           state,
    output logic                 locked,
    output logic                 err,
    output logic [6:0]           err_bits,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [BIT_CNT_W-1:0] bit_cnt
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } StateType;

    // Sums are formed one bit wider than the widest operand so overflow is visible.
    localparam int EW = ((ERR_CNT_W > 7) ? ERR_CNT_W : 7) + 1;
    localparam int BW = ((BIT_CNT_W > 7) ? BIT_CNT_W : 7) + 1;
    localparam logic [EW-1:0] ERR_MAX    = {{(EW-ERR_CNT_W){1'b0}}, {ERR_CNT_W{1'b1}}};
    localparam logic [BW-1:0] BIT_MAX    = {{(BW-BIT_CNT_W){1'b0}}, {BIT_CNT_W{1'b1}}};
    localparam logic [BW-1:0] BIT_INC    = BW'(WIDTH);
    localparam logic [7:0]    FILL_INC   = 8'(WIDTH);
    localparam logic [4:0]    FILL_FRESH = (WIDTH > 31) ? 5'd31 : 5'(WIDTH);
    localparam logic [7:0]    LOCK_LIM   = 8'(LOCK_THRESH);
    localparam logic [7:0]    UNLOCK_LIM = 8'(UNLOCK_THRESH);

    StateType               r_state;
    logic [30:0]            r_hist;
    logic [4:0]             r_fill;
    logic [7:0]             r_cleanRun;
    logic [7:0]             r_badRun;
    logic [2:0]             r_mode;
    logic                   r_locked;
    logic                   r_err;
    logic [6:0]             r_errBits;
    logic [ERR_CNT_W-1:0]   r_errCnt;
    logic [BIT_CNT_W-1:0]   r_bitCnt;

    logic [4:0]             w_order;
    logic [4:0]             w_tapN;
    logic [4:0]             w_tapT;
    logic [30:0]            w_predHist;
    logic [30:0]            w_rxHist;
    logic [WIDTH-1:0]       w_pred;
    logic [WIDTH-1:0]       w_diff;
    logic [6:0]             w_errBits;
    logic                   w_wordBad;
    logic                   w_modeChange;
    logic [7:0]             w_fillSum;
    logic [4:0]             w_fillNext;
    logic [EW-1:0]          w_errSum;
    logic [BW-1:0]          w_bitSum;

    // Polynomial decode: order N and the history positions of b[n-N] and b[n-T].
    always_comb begin
        case (mode)
            3'd1:    begin w_order = 5'd9;  w_tapN = 5'd8;  w_tapT = 5'd4;  end
            3'd2:    begin w_order = 5'd15; w_tapN = 5'd14; w_tapT = 5'd13; end
            3'd3:    begin w_order = 5'd23; w_tapN = 5'd22; w_tapT = 5'd17; end
            3'd4:    begin w_order = 5'd31; w_tapN = 5'd30; w_tapT = 5'd27; end
            default: begin w_order = 5'd7;  w_tapN = 5'd6;  w_tapT = 5'd5;  end
        endcase
    end

    // Unrolled prediction in time order; r_hist[0] holds the most recent bit.
    always_comb begin
        w_predHist = r_hist;
        w_rxHist   = r_hist;
        w_pred     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pred[i]  = w_predHist[w_tapN] ^ w_predHist[w_tapT];
            w_predHist = {w_predHist[29:0], w_pred[i]};
            w_rxHist   = {w_rxHist[29:0], din[i]};
        end
    end

    // Mismatch popcount of the current word against the prediction.
    always_comb begin
        w_diff    = din ^ w_pred;
        w_errBits = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_errBits = w_errBits + {6'd0, w_diff[i]};
        end
    end

    assign w_wordBad    = (w_errBits != 7'd0);
    assign w_modeChange = (mode != r_mode);
    assign w_fillSum    = {3'd0, r_fill} + FILL_INC;
    assign w_fillNext   = (w_fillSum > 8'd31) ? 5'd31 : w_fillSum[4:0];
    assign w_errSum     = EW'(r_errCnt) + EW'(w_errBits);
    assign w_bitSum     = BW'(r_bitCnt) + BIT_INC;

    // Sequencer: state transitions, history update and the registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= SEARCH;
            r_hist     <= '0;
            r_fill     <= '0;
            r_cleanRun <= '0;
            r_badRun   <= '0;
            r_mode     <= mode;
            r_locked   <= 1'b0;
            r_err      <= 1'b0;
            r_errBits  <= '0;
            r_errCnt   <= '0;
            r_bitCnt   <= '0;
        end else begin
            r_mode    <= mode;
            r_err     <= 1'b0;
            r_errBits <= '0;
            if (!en || (w_modeChange && (r_state != SEARCH))) begin
                r_state    <= SEARCH;
                r_locked   <= 1'b0;
                r_fill     <= '0;
                r_cleanRun <= '0;
                r_badRun   <= '0;
            end else if (din_valid) begin
                case (r_state)
                    SEARCH: begin
                        r_hist <= w_rxHist;
                        r_fill <= w_fillNext;
                        if (w_fillNext >= w_order) begin
                            r_state    <= VERIFY;
                            r_cleanRun <= '0;
                        end
                    end
                    VERIFY: begin
                        if (w_wordBad) begin
                            r_state    <= SEARCH;
                            r_hist     <= w_rxHist;
                            r_fill     <= FILL_FRESH;
                            r_cleanRun <= '0;
                        end else begin
                            r_hist <= w_predHist;
                            if ((r_cleanRun + 8'd1) >= LOCK_LIM) begin
                                r_state    <= LOCKED;
                                r_locked   <= 1'b1;
                                r_cleanRun <= '0;
                                r_badRun   <= '0;
                            end else begin
                                r_cleanRun <= r_cleanRun + 8'd1;
                            end
                        end
                    end
                    LOCKED: begin
                        r_hist    <= w_predHist;
                        r_errBits <= w_errBits;
                        r_err     <= w_wordBad;
                        r_errCnt  <= (w_errSum > ERR_MAX) ? ERR_MAX[ERR_CNT_W-1:0]
                                                          : w_errSum[ERR_CNT_W-1:0];
                        r_bitCnt  <= (w_bitSum > BIT_MAX) ? BIT_MAX[BIT_CNT_W-1:0]
                                                          : w_bitSum[BIT_CNT_W-1:0];
                        if (w_wordBad) begin
                            if ((r_badRun + 8'd1) >= UNLOCK_LIM) begin
                                r_state    <= SEARCH;
                                r_locked   <= 1'b0;
                                r_fill     <= '0;
                                r_badRun   <= '0;
                                r_cleanRun <= '0;
                            end else begin
                                r_badRun <= r_badRun + 8'd1;
                            end
                        end else begin
                            r_badRun <= '0;
                        end
                    end
                    default: begin
                        r_state  <= SEARCH;
                        r_locked <= 1'b0;
                        r_fill   <= '0;
                    end
                endcase
            end
            if (clr_cnt) begin
                r_errCnt <= '0;
                r_bitCnt <= '0;
            end
        end
    end

    assign state    = r_state;
    assign locked   = r_locked;
    assign err      = r_err;
    assign err_bits = r_errBits;
    assign err_cnt  = r_errCnt;
    assign bit_cnt  = r_bitCnt;

endmodule
